addsub_operand_loader: RTL and testbench
========================================

# addsub_operand_loader

Sequential front end for the combinational add/subtract unit. Accepts two operands over a valid/ready byte stream, registers them with the operation select, and drives the adder's `a`/`b`/`op` inputs. One cycle later it captures the adder's `s` into a held result register and offers it downstream on a second valid/ready handshake. The adder itself stays outside this block, wired between `add_a/add_b/add_op` and `add_s`.

## Interface
- `WIDTH`, 8, operand/result width in bits.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `in_data`  in  WIDTH  operand word; first accepted word is A, second is B.
- `in_op`  in  1  0 = add, 1 = subtract; sampled only with the B word.
- `add_a`  out  WIDTH  registered operand A to the adder.
- `add_b`  out  WIDTH  registered operand B to the adder.
- `add_op`  out  1  registered op select to the adder.
- `add_s`  in  WIDTH  adder result; combinational from `add_a/add_b/add_op`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts result.
- `out_result`  out  WIDTH  captured result.
- `busy`  out  1  high in any state other than IDLE.
- `out_zero`, `out_ovf`  out  1 each  result flags; present only with `ADDSUB_FLAGS_EN`.

## Operation
- FSM states: IDLE, WAIT_B, EXEC, DONE.
- IDLE: `in_ready`=1. On `in_valid`, latch `in_data` into `add_a` and go to WAIT_B.
- WAIT_B: `in_ready`=1. On `in_valid`, latch `in_data` into `add_b` and `in_op` into `add_op`, then go to EXEC.
- EXEC: `in_ready`=0. The adder settles. At the end of the cycle, capture `add_s` into `out_result` (and the flags) and go to DONE.
- DONE: `in_ready`=0, `out_valid`=1. `out_result` is held stable. On `out_ready`, go to IDLE.
- `add_a`, `add_b` and `add_op` change only when a word is accepted. They hold between operations.
- `out_result` holds its last value after the handshake until the next capture.
- Arithmetic, as performed by the adder: s = (a + b) mod 2^WIDTH, or s = (a − b) mod 2^WIDTH, two's complement. No carry or borrow output.
- Words presented in EXEC or DONE are not accepted. Upstream must hold them until `in_ready` goes high.
- Reset state: state = IDLE. `in_ready`=1. `add_a`=`add_b`=0, `add_op`=0. `out_valid`=0, `out_result`=0, `busy`=0, flags=0.
- Reset asserted in any state, including mid-operation, discards partial operands and any pending result. There is no output glitch beyond the synchronous clear.

## Timing
- B accepted at edge N. EXEC occupies cycle N..N+1. `out_valid` is high from edge N+1.
- Minimum A-to-result latency is 3 edges.
- Minimum back-to-back period is 4 cycles per operation: A, B, EXEC, DONE with `out_ready` already high.
- `out_valid` stays high until the edge where `out_valid & out_ready` are both seen. IDLE is entered at that edge, and a new A is accepted on the following edge at the earliest.
- `out_ready` has no effect outside DONE.
- `in_valid` held continuously in IDLE→WAIT_B accepts two consecutive words on consecutive edges.

## Configuration
- Macro: `ADDSUB_FLAGS_EN`.
- Defined:
  - `out_zero` = (captured result == 0).
  - `out_ovf` = signed overflow. For add: `a[MSB]==b[MSB]` and `s[MSB]!=a[MSB]`. For subtract: `a[MSB]!=b[MSB]` and `s[MSB]!=a[MSB]`.
  - Both flags are registered with `out_result` in EXEC and reset to 0.
- Undefined: both flag ports and their logic are absent. Everything else is unchanged.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 edges → all outputs at reset values, `in_ready`=1, `busy`=0.
- Add: A=0xFF, B=0xFF, op=0, `out_ready`=1 → `add_a`=0xFF, `add_b`=0xFF; `out_result`=0xFE with `out_valid` 2 edges after B. Flags: zero=0, ovf=0.
- Subtract with backpressure: A=0xFE, B=0x10, op=1, `out_ready`=0 for 5 cycles → `out_valid` held, `out_result`=0xEE stable. Raise `out_ready` → back to IDLE next edge.
- Flags (`ADDSUB_FLAGS_EN`): 0x7F+0x01 → 0x80, ovf=1. 0x10−0x10 → 0x00, zero=1, ovf=0. 0x80−0x01 → 0x7F, ovf=1.
- Stall input: `in_valid` held high with new data during EXEC/DONE → word not consumed, `in_ready`=0. Word is accepted as the next A once IDLE is reached.
- Reset mid-op: assert `rst_n`=0 in WAIT_B after A=0x55 → next cycle IDLE, `add_a`=0, `out_valid` never asserted.

Source files
------------

// File: rtl/addsub_operand_loader.sv
// rtl/addsub_operand_loader.sv - operand/result sequencer around an external add/sub unit
// Optional result flags (out_zero, out_ovf) are built only with ADDSUB_FLAGS_EN defined.
module addsub_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    input  logic [WIDTH-1:0] add_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
`ifdef ADDSUB_FLAGS_EN
    output logic             out_zero,
    output logic             out_ovf,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_B = 2'd1,
        S_EXEC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              op_q, op_d;
    logic [WIDTH-1:0]  result_q, result_d;

`ifdef ADDSUB_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
    logic a_msb, b_msb, s_msb;

    assign a_msb = a_q[WIDTH-1];
    assign b_msb = b_q[WIDTH-1];
    assign s_msb = add_s[WIDTH-1];
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
`ifdef ADDSUB_FLAGS_EN
        zero_d   = zero_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = S_WAIT_B;
                end
            end
            S_WAIT_B: begin
                if (in_valid) begin
                    b_d     = in_data;
                    op_d    = in_op;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // add_s has had the whole cycle to settle from the registered operands
                result_d = add_s;
`ifdef ADDSUB_FLAGS_EN
                zero_d   = (add_s == '0);
                ovf_d    = (op_q ? (a_msb != b_msb) : (a_msb == b_msb)) && (s_msb != a_msb);
`endif
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
`ifdef ADDSUB_FLAGS_EN
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
`ifdef ADDSUB_FLAGS_EN
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready   = (state_q == S_IDLE) || (state_q == S_WAIT_B);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign add_a      = a_q;
    assign add_b      = b_q;
    assign add_op     = op_q;
    assign out_result = result_q;
`ifdef ADDSUB_FLAGS_EN
    assign out_zero   = zero_q;
    assign out_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_operand_loader.sv
// tb/tb_addsub_operand_loader.sv - self-checking bench with behavioural adder and reference model
module tb_addsub_operand_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_op;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_op;
    logic [W-1:0] add_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         busy;
`ifdef ADDSUB_FLAGS_EN
    logic         out_zero;
    logic         out_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // The external adder the loader drives.
    assign add_s = add_op ? (add_a - add_b) : (add_a + add_b);

    addsub_operand_loader #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_op      (in_op),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_op     (add_op),
        .add_s      (add_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef ADDSUB_FLAGS_EN
        .out_zero   (out_zero),
        .out_ovf    (out_ovf),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_result(input int a, input int b, input bit op);
        int r;
        r = op ? (a - b) : (a + b);
        return ((r % (1 << W)) + (1 << W)) % (1 << W);
    endfunction

    function automatic bit ref_ovf(input int a, input int b, input bit op);
        int sa, sb, r;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        r  = op ? (sa - sb) : (sa + sb);
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit op,
                          input int hold, input bit stall, input logic [W-1:0] stall_word,
                          input bit early_rdy);
        int exp;
        exp = ref_result(int'(a), int'(b), op);
        in_valid  = 1'b1;
        in_data   = a;
        in_op     = ~op;
        out_ready = early_rdy;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        tick();
        chk("a_latched", add_a, a);
        chk("waitb_in_ready", in_ready, 1);
        chk("waitb_busy", busy, 1);
        in_data = b;
        in_op   = op;
        tick();
        chk("b_latched", add_b, b);
        chk("op_latched", add_op, op);
        chk("exec_in_ready", in_ready, 0);
        chk("exec_out_valid", out_valid, 0);
        in_valid = stall;
        in_data  = stall_word;
        in_op    = 1'($urandom);
        tick();
        chk("done_out_valid", out_valid, 1);
        chk("done_result", out_result, exp);
        chk("done_in_ready", in_ready, 0);
        chk("done_a_held", add_a, a);
`ifdef ADDSUB_FLAGS_EN
        chk("flag_zero", out_zero, exp == 0);
        chk("flag_ovf", out_ovf, ref_ovf(int'(a), int'(b), op));
`endif
        out_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_result", out_result, exp);
            chk("hold_a_stall", add_a, a);
            if (i == hold - 1) out_ready = 1'b1;
        end
        tick();
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_result_held", out_result, exp);
        chk("post_a_held", add_a, a);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, nxt;
        bit           rop, rstall;
        int           rhold;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_op     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_op", add_op, 0);
        chk("rst_out_result", out_result, 0);
`ifdef ADDSUB_FLAGS_EN
        chk("rst_zero", out_zero, 0);
        chk("rst_ovf", out_ovf, 0);
`endif
        rst_n = 1'b1;
        tick();

        run_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, 8'h00, 1'b1);
        run_op(8'hFE, 8'h10, 1'b1, 5, 1'b0, 8'h00, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        run_op(8'h10, 8'h10, 1'b1, 1, 1'b0, 8'h00, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 0, 1'b1, 8'h3C, 1'b1);
        run_op(8'h3C, 8'hC4, 1'b0, 2, 1'b0, 8'h00, 1'b0);

        nxt = 8'($urandom);
        rstall = 1'b0;
        for (int k = 0; k < 24; k++) begin
            ra     = rstall ? nxt : 8'($urandom);
            rb     = 8'($urandom);
            rop    = 1'($urandom);
            rhold  = $urandom_range(0, 3);
            rstall = 1'($urandom);
            nxt    = 8'($urandom);
            run_op(ra, rb, rop, rhold, rstall, nxt, 1'($urandom));
        end
        if (rstall) begin
            run_op(nxt, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b0);
        end

        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        chk("midrst_a", add_a, 8'h55);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("midrst_add_a", add_a, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", out_result, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_valid", out_valid, 0);
            chk("midrst_idle", busy, 0);
        end

        run_op(8'h01, 8'h02, 1'b1, 0, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
